// File: rtl/vga_bouncing_rect_if.sv
// rtl/vga_bouncing_rect_if.sv - pixel-side bundle between the sync block, the rectangle generator and the RGB pins
//
// Signals:
//   pos_h, pos_v : horizontal / vertical counters from the sync block
//   blank        : high outside the active area
//   color_sel    : one-hot colour select (switches)
//   run          : high lets the rectangle move, low freezes it
//   red/green/blue : registered colour outputs
//   frame_tick   : one-cycle pulse at the start of vertical blanking
// Modports: master drives the counters/controls and receives pixels; slave is the generator.
interface vga_bouncing_rect_if;
  logic [9:0] pos_h;
  logic [9:0] pos_v;
  logic       blank;
  logic [2:0] color_sel;
  logic       run;
  logic       red;
  logic       green;
  logic       blue;
  logic       frame_tick;

  modport master (
    output pos_h, pos_v, blank, color_sel, run,
    input  red, green, blue, frame_tick
  );

  modport slave (
    input  pos_h, pos_v, blank, color_sel, run,
    output red, green, blue, frame_tick
  );
endinterface

// File: rtl/vga_bouncing_rect.sv
// rtl/vga_bouncing_rect.sv - solid (or outlined) rectangle that bounces around the VGA active area
//
// Ports:
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : vga_bouncing_rect_if.slave (counters, blank, colour select, run in; rgb, frame_tick out)
// Optional build macro: VGA_RECT_OUTLINE_EN lights only an OUTLINE-pixel border of the rectangle.
// Outputs are registered one pixel clock behind the counter inputs.
module vga_bouncing_rect #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WIDTH    = 20,
  parameter int HEIGHT   = 100,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240,
  parameter int STEP     = 2,
  parameter int OUTLINE  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_bouncing_rect_if.slave  bus
);

  localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - WIDTH);
  localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - HEIGHT);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] W_W     = 11'(WIDTH);
  localparam logic [10:0] H_W     = 11'(HEIGHT);
  localparam logic [10:0] OL_W    = 11'(OUTLINE);
  localparam logic [10:0] Y_TOP   = 11'(V_ACTIVE - 1);
  localparam logic [9:0]  V_BLANK = 10'(V_ACTIVE);

  logic [10:0] x_left, y_bottom;
  logic        dx_neg, dy_neg;
  logic [9:0]  pos_v_d;
  logic [2:0]  rgb_q;
  logic        tick_q;

  logic [10:0] x, y;
  logic        on_rect, on_border, lit;
  logic [2:0]  colour, rgb_next;
  logic        tick_now;
  logic [10:0] x_next, y_next;
  logic        dx_neg_next, dy_neg_next;

  // Screen y grows upward from the bottom line; wraps for pos_v >= V_ACTIVE, but blank covers that.
  assign x = {1'b0, bus.pos_h};
  assign y = Y_TOP - {1'b0, bus.pos_v};

  assign on_rect   = (x >= x_left) && (x < x_left + W_W) &&
                     (y >= y_bottom) && (y < y_bottom + H_W);
  assign on_border = (x < x_left + OL_W) || (x >= x_left + W_W - OL_W) ||
                     (y < y_bottom + OL_W) || (y >= y_bottom + H_W - OL_W);

`ifdef VGA_RECT_OUTLINE_EN
  assign lit = on_rect && on_border;
`else
  assign lit = on_rect;
  logic unused_border;
  assign unused_border = on_border;
`endif

  always_comb begin
    colour = 3'b111;
    case (bus.color_sel)
      3'b001:  colour = 3'b110;
      3'b010:  colour = 3'b101;
      3'b100:  colour = 3'b011;
      default: colour = 3'b111;
    endcase
  end

  assign rgb_next = (!bus.blank && lit) ? colour : 3'b000;

  // Rising into the first blanking line, not merely being on it.
  assign tick_now = (bus.pos_v == V_BLANK) && (pos_v_d != V_BLANK);

  // Bounce rule: reaching or passing a limit clamps onto it and reverses.
  always_comb begin
    x_next      = x_left;
    dx_neg_next = dx_neg;
    if (!dx_neg) begin
      if (x_left + STEP_W >= X_MAX) begin
        x_next      = X_MAX;
        dx_neg_next = 1'b1;
      end else begin
        x_next = x_left + STEP_W;
      end
    end else begin
      if (x_left <= STEP_W) begin
        x_next      = 11'd0;
        dx_neg_next = 1'b0;
      end else begin
        x_next = x_left - STEP_W;
      end
    end
  end

  always_comb begin
    y_next      = y_bottom;
    dy_neg_next = dy_neg;
    if (!dy_neg) begin
      if (y_bottom + STEP_W >= Y_MAX) begin
        y_next      = Y_MAX;
        dy_neg_next = 1'b1;
      end else begin
        y_next = y_bottom + STEP_W;
      end
    end else begin
      if (y_bottom <= STEP_W) begin
        y_next      = 11'd0;
        dy_neg_next = 1'b0;
      end else begin
        y_next = y_bottom - STEP_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q    <= 3'b000;
      tick_q   <= 1'b0;
      pos_v_d  <= 10'd0;
      x_left   <= 11'(X_INIT);
      y_bottom <= 11'(Y_INIT);
      dx_neg   <= 1'b0;
      dy_neg   <= 1'b0;
    end else begin
      rgb_q   <= rgb_next;
      tick_q  <= tick_now;
      pos_v_d <= bus.pos_v;
      if (tick_now && bus.run) begin
        x_left   <= x_next;
        y_bottom <= y_next;
        dx_neg   <= dx_neg_next;
        dy_neg   <= dy_neg_next;
      end
    end
  end

  assign bus.red        = rgb_q[2];
  assign bus.green      = rgb_q[1];
  assign bus.blue       = rgb_q[0];
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_bouncing_rect.sv
// tb/tb_vga_bouncing_rect.sv - self-checking bench for vga_bouncing_rect
module tb_vga_bouncing_rect;

  logic clk;
  logic rst_n;
  vga_bouncing_rect_if bus();

  vga_bouncing_rect dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;

  // Reference position model: integer coordinates, direction as +1/-1.
  int mx, my, mdx, mdy;

  typedef struct {
    int         h;
    int         v;
    bit         blank;
    logic [2:0] cs;
    logic [2:0] exp;
    bit         interior;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rgb_now();
    return {29'd0, bus.red, bus.green, bus.blue};
  endfunction

  function automatic void model_reset();
    mx = 320; my = 240; mdx = 1; mdy = 1;
  endfunction

  function automatic void axis_step(inout int p, inout int d, input int lim);
    int t;
    t = p + d * 2;
    if (t >= lim) begin p = lim; d = -1; end
    else if (t <= 0) begin p = 0; d = 1; end
    else p = t;
  endfunction

  function automatic void model_step();
    axis_step(mx, mdx, 640 - 20);
    axis_step(my, mdy, 480 - 100);
  endfunction

  function automatic int ref_rgb(input int h, input int v, input bit bl, input logic [2:0] cs);
    int  y;
    bit  in;
    y  = 479 - v;
    in = (h >= mx) && (h < mx + 20) && (y >= my) && (y < my + 100);
`ifdef VGA_RECT_OUTLINE_EN
    in = in && (h < mx + 2 || h >= mx + 18 || y < my + 2 || y >= my + 98);
`endif
    if (bl || !in) return 0;
    case (cs)
      3'b001:  return 6;
      3'b010:  return 5;
      3'b100:  return 3;
      default: return 7;
    endcase
  endfunction

  task automatic pixel(input int h, input int v, input bit bl, input logic [2:0] cs);
    bus.pos_h = 10'(h); bus.pos_v = 10'(v); bus.blank = bl; bus.color_sel = cs;
    @(posedge clk); #1;
  endtask

  task automatic random_pixel();
    int h, v;
    bit bl;
    logic [2:0] cs;
    if ($urandom_range(0, 1) == 1) begin
      h = mx - 5 + int'($urandom_range(0, 30));
      v = 479 - (my - 5 + int'($urandom_range(0, 110)));
    end else begin
      h = int'($urandom_range(0, 639));
      v = int'($urandom_range(0, 479));
    end
    if (h < 0) h = 0;
    if (h > 639) h = 639;
    if (v < 0) v = 0;
    if (v > 479) v = 479;
    bl = ($urandom_range(0, 7) == 0);
    cs = 3'($urandom_range(0, 7));
    pixel(h, v, bl, cs);
    chk("rand_rgb", rgb_now(), ref_rgb(h, v, bl, cs));
  endtask

  task automatic frame();
    bus.blank = 1'b1; bus.pos_v = 10'd479;
    @(posedge clk); #1;
    bus.pos_v = 10'd480;
    @(posedge clk); #1;
    chk("frame_tick_pulse", int'(bus.frame_tick), 1);
    if (bus.frame_tick) ticks++;
    if (bus.run) model_step();
    chk("x_left", int'(dut.x_left), mx);
    chk("y_bottom", int'(dut.y_bottom), my);
    @(posedge clk); #1;
    chk("frame_tick_hold", int'(bus.frame_tick), 0);
    bus.pos_v = 10'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    vecs.push_back('{320, 239, 1'b0, 3'b001, 3'b110, 1'b0});
    vecs.push_back('{340, 239, 1'b0, 3'b001, 3'b000, 1'b0});
    vecs.push_back('{339, 239, 1'b0, 3'b001, 3'b110, 1'b0});
    vecs.push_back('{319, 239, 1'b0, 3'b001, 3'b000, 1'b0});
    vecs.push_back('{320, 239, 1'b0, 3'b000, 3'b111, 1'b0});
    vecs.push_back('{325, 140, 1'b0, 3'b010, 3'b101, 1'b0});
    vecs.push_back('{325, 139, 1'b0, 3'b010, 3'b000, 1'b0});
    vecs.push_back('{325, 240, 1'b0, 3'b100, 3'b000, 1'b0});
    vecs.push_back('{321, 200, 1'b0, 3'b100, 3'b011, 1'b0});
    vecs.push_back('{321, 200, 1'b0, 3'b011, 3'b111, 1'b0});
    vecs.push_back('{330, 189, 1'b0, 3'b001, 3'b110, 1'b1});
    vecs.push_back('{330, 189, 1'b1, 3'b001, 3'b000, 1'b0});
    vecs.push_back('{320, 239, 1'b1, 3'b111, 3'b000, 1'b0});

    rst_n = 1'b0;
    bus.pos_h = 10'd0; bus.pos_v = 10'd0; bus.blank = 1'b1;
    bus.color_sel = 3'b001; bus.run = 1'b0;
    model_reset();
    #3;
    chk("reset_rgb", rgb_now(), 0);
    chk("reset_tick", int'(bus.frame_tick), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("reset_x", int'(dut.x_left), 320);
    chk("reset_y", int'(dut.y_bottom), 240);

    foreach (vecs[i]) begin
      logic [2:0] e;
      e = vecs[i].exp;
`ifdef VGA_RECT_OUTLINE_EN
      if (vecs[i].interior) e = 3'b000;
`endif
      pixel(vecs[i].h, vecs[i].v, vecs[i].blank, vecs[i].cs);
      chk($sformatf("vec%0d_rgb", i), rgb_now(), int'(e));
    end

`ifdef VGA_RECT_OUTLINE_EN
    pixel(320, 189, 1'b0, 3'b010);
    chk("outline_left_edge", rgb_now(), 5);
`endif

    bus.run = 1'b1;
    frame();
    chk("frame1_x", int'(dut.x_left), 322);
    chk("frame1_y", int'(dut.y_bottom), 242);
    for (int f = 2; f <= 151; f++) begin
      frame();
      if (f == 70)  chk("frame70_y_clamp", int'(dut.y_bottom), 380);
      if (f == 71)  chk("frame71_y_back", int'(dut.y_bottom), 378);
      if (f == 150) chk("frame150_x_clamp", int'(dut.x_left), 620);
      if (f == 151) chk("frame151_x_back", int'(dut.x_left), 618);
      random_pixel();
      random_pixel();
    end

    bus.run = 1'b0;
    ticks = 0;
    for (int f = 0; f < 5; f++) frame();
    chk("frozen_ticks", ticks, 5);
    chk("frozen_x", int'(dut.x_left), 618);
    chk("frozen_y", int'(dut.y_bottom), 380 - 2 * (151 - 70));

    for (int i = 0; i < 200; i++) random_pixel();

    bus.run = 1'b1;
    for (int f = 0; f < 10; f++) frame();
    pixel(mx, 479 - my, 1'b0, 3'b001);
    chk("pre_reset_lit", rgb_now(), 6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_rgb", rgb_now(), 0);
    chk("async_reset_tick", int'(bus.frame_tick), 0);
    chk("async_reset_x", int'(dut.x_left), 320);
    model_reset();
    bus.pos_v = 10'd0; bus.blank = 1'b1;
    @(posedge clk); #2 rst_n = 1'b1;

    bus.pos_v = 10'd479;
    @(posedge clk); #1;
    bus.pos_v = 10'd480;
    @(posedge clk); #1;
    chk("tick_before_reset", int'(bus.frame_tick), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tick_clear", int'(bus.frame_tick), 0);
    model_reset();
    bus.pos_v = 10'd0;
    @(posedge clk); #2 rst_n = 1'b1;

    frame();
    chk("after_reset_x", int'(dut.x_left), 322);
    chk("after_reset_y", int'(dut.y_bottom), 242);
    for (int i = 0; i < 20; i++) random_pixel();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
